// File: rtl/bird_motion.sv
`default_nettype none
// ============================================================================
//  Module   : bird_motion
//  Brief    : Bird vertical motion for a flappy-style game. Synchronizes the
//             slow game clock and the player buttons, then integrates
//             velocity/position once per game tick with ceiling clamp and
//             floor detection (IDLE / RUN / DEAD).
//  Revision : 1.0 - initial release
// ============================================================================
module bird_motion #(
    parameter logic [7:0] Y_START  = 8'd120,
    parameter logic [7:0] Y_MAX    = 8'd239,
    parameter int         GRAVITY  = 1,
    parameter int         FLAP_VEL = -6,
    parameter int         VEL_MAX  = 7
) (
    input  logic              clock_in,
    input  logic              reset_n,
    input  logic              game_clk,
    input  logic              flap,
    input  logic              start,
    output logic [7:0]        bird_y,
    output logic signed [5:0] bird_vel,
    output logic              tick,
    output logic              running,
    output logic              game_over
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    // 10-bit signed working copies of the motion constants
    localparam logic signed [9:0] c_gravity  = 10'(GRAVITY);
    localparam logic signed [9:0] c_flap_vel = 10'(FLAP_VEL);
    localparam logic signed [9:0] c_vel_max  = 10'(VEL_MAX);
    localparam logic signed [9:0] c_y_max    = {2'b00, Y_MAX};

    // Bit 0/1: two-flop synchronizer, bit 2: edge-detect history
    logic [2:0]        r_gclk_sync;
    logic [2:0]        r_flap_sync;
    logic [2:0]        r_start_sync;
    // Edge detection stays masked until the edge-detect stage holds a real
    // post-reset sample, so levels already high in reset create no edge.
    logic [1:0]        r_arm_cnt;
    logic              r_tick;
    logic              r_pend;
    logic [7:0]        r_y;
    logic signed [5:0] r_vel;
    state_t            r_state;

    logic              w_armed;
    logic              w_gclk_rise;
    logic              w_flap_rise;
    logic              w_start_rise;
    logic              w_flap_now;
    logic signed [9:0] w_vel_ext;
    logic signed [9:0] w_vel_inc;
    logic signed [9:0] w_vel_calc;
    logic signed [9:0] w_y_ext;
    logic signed [9:0] w_y_calc;
    state_t            w_state_d;
    logic [7:0]        w_y_d;
    logic signed [5:0] w_vel_d;
    logic              w_pend_d;

    assign w_armed      = (r_arm_cnt == 2'd3);
    assign w_gclk_rise  = w_armed & r_gclk_sync[1]  & ~r_gclk_sync[2];
    assign w_flap_rise  = w_armed & r_flap_sync[1]  & ~r_flap_sync[2];
    assign w_start_rise = w_armed & r_start_sync[1] & ~r_start_sync[2];

    // Synchronize asynchronous inputs, arm edge detection, register the tick
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_gclk_sync  <= '0;
            r_flap_sync  <= '0;
            r_start_sync <= '0;
            r_arm_cnt    <= '0;
            r_tick       <= 1'b0;
        end else begin
            r_gclk_sync  <= {r_gclk_sync[1:0], game_clk};
            r_flap_sync  <= {r_flap_sync[1:0], flap};
            r_start_sync <= {r_start_sync[1:0], start};
            if (r_arm_cnt != 2'd3) begin
                r_arm_cnt <= r_arm_cnt + 2'd1;
            end
            r_tick       <= w_gclk_rise;
        end
    end

    // Motion arithmetic: a flap arriving in the tick cycle counts for that tick
    always_comb begin
        w_flap_now = r_pend | w_flap_rise;
        w_vel_ext  = {{4{r_vel[5]}}, r_vel};
        w_vel_inc  = w_vel_ext + c_gravity;
        if (w_flap_now) begin
            w_vel_calc = c_flap_vel;
        end else if (w_vel_inc > c_vel_max) begin
            w_vel_calc = c_vel_max;
        end else begin
            w_vel_calc = w_vel_inc;
        end
        w_y_ext  = {2'b00, r_y};
        w_y_calc = w_y_ext + w_vel_calc;
    end

    // Next state and next motion values
    always_comb begin
        w_state_d = r_state;
        w_y_d     = r_y;
        w_vel_d   = r_vel;
        w_pend_d  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_y_d   = Y_START;
                w_vel_d = '0;
                if (w_start_rise) begin
                    w_state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_tick) begin
                    if (w_y_calc < 10'sd0) begin
                        w_y_d   = '0;
                        w_vel_d = w_vel_calc[5:0];
                    end else if (w_y_calc >= c_y_max) begin
                        w_y_d     = Y_MAX;
                        w_vel_d   = '0;
                        w_state_d = ST_DEAD;
                    end else begin
                        w_y_d   = w_y_calc[7:0];
                        w_vel_d = w_vel_calc[5:0];
                    end
                end else begin
                    w_pend_d = r_pend | w_flap_rise;
                end
            end
            ST_DEAD: begin
                if (w_start_rise) begin
                    w_state_d = ST_IDLE;
                    w_y_d     = Y_START;
                    w_vel_d   = '0;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_y_d     = Y_START;
                w_vel_d   = '0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Bird position, velocity and pending-flap registers
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_y    <= Y_START;
            r_vel  <= '0;
            r_pend <= 1'b0;
        end else begin
            r_y    <= w_y_d;
            r_vel  <= w_vel_d;
            r_pend <= w_pend_d;
        end
    end

    assign bird_y    = r_y;
    assign bird_vel  = r_vel;
    assign tick      = r_tick;
    assign running   = (r_state == ST_RUN);
    assign game_over = (r_state == ST_DEAD);

endmodule
`default_nettype wire
